mc_main_cu: RTL and testbench

- Multicycle main control FSM for the CA2 MIPS-subset datapath.
- Sits directly upstream of the ALU control unit: drives its 2-bit alu_op, and the instruction-register func field feeds that unit in parallel.
- Sequences IF/ID/EX/MEM/WB per opcode and produces all datapath enables and mux selects.
- Keeps a retired-instruction counter.

---
 rtl/mc_main_cu.sv | 204 ++++++++++++++++++++
 tb/tb_mc_main_cu.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mc_main_cu.sv
// Multicycle main control FSM for the MIPS-subset datapath: state sequencing, Moore
// datapath controls, look-ahead alu_op and retired-instruction counter. Option: ILLEGAL_OP_TRAP_EN.
module mc_main_cu #(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic [5:0]         func,
  input  logic               zero,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic [1:0]         reg_dst,
  output logic [1:0]         mem_to_reg,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         pc_src,
  output logic [1:0]         alu_op,
  output logic               halted,
  output logic [COUNT_W-1:0] instr_count
);

  // state      | meaning
  // IF         | fetch, PC += 4
  // ID         | decode, branch target into ALUOut
  // EX_R/WB_R  | R-type execute / write rd
  // EX_I/WB_I  | addi/slti execute / write rt
  // MEM_ADDR   | lw/sw address calculation
  // MEM_RD     | data read ; WB_LW writes MDR to rt
  // MEM_WR     | data write
  // BR         | beq compare, conditional PC load
  // JMP/JAL/JR | jump, jump-and-link, jump-register
  // HALT       | illegal-opcode trap (trap build only)
  typedef enum logic [3:0] {
    S_IF, S_ID, S_EX_R, S_WB_R, S_EX_I, S_WB_I, S_MEM_ADDR, S_MEM_RD,
    S_WB_LW, S_MEM_WR, S_BR, S_JMP, S_JAL, S_JR, S_HALT
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  state_t state, next_state;

  // zero gates pc_write_cond in the datapath; the FSM itself never branches on it.
  logic unused_zero;
  assign unused_zero = zero;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IF;
      instr_count <= '0;
    end else begin
      state <= next_state;
      if (next_state == S_IF)
        instr_count <= instr_count + {{(COUNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_comb begin
    next_state    = state;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 2'd0;
    mem_to_reg    = 2'd0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'd0;
    pc_src        = 2'd0;
    alu_op        = 2'b01;
    case (state)
      S_IF: begin
        mem_read   = 1'b1;
        ir_write   = 1'b1;
        pc_write   = 1'b1;
        alu_src_b  = 2'd1;
        next_state = S_ID;
      end
      S_ID: begin
        alu_src_b = 2'd3;
        case (opcode)
          OP_RTYPE:        next_state = (func == FN_JR) ? S_JR : S_EX_R;
          OP_ADDI, OP_SLTI: next_state = S_EX_I;
          OP_LW, OP_SW:    next_state = S_MEM_ADDR;
          OP_BEQ:          next_state = S_BR;
          OP_J:            next_state = S_JMP;
          OP_JAL:          next_state = S_JAL;
`ifdef ILLEGAL_OP_TRAP_EN
          default:         next_state = S_HALT;
`else
          default:         next_state = S_IF;
`endif
        endcase
      end
      S_EX_R: begin
        alu_src_a  = 1'b1;
        next_state = S_WB_R;
      end
      S_WB_R: begin
        reg_write  = 1'b1;
        reg_dst    = 2'd1;
        next_state = S_IF;
      end
      S_EX_I: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'd2;
        next_state = S_WB_I;
      end
      S_WB_I: begin
        reg_write  = 1'b1;
        next_state = S_IF;
      end
      S_MEM_ADDR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'd2;
        next_state = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_read   = 1'b1;
        i_or_d     = 1'b1;
        next_state = S_WB_LW;
      end
      S_WB_LW: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'd1;
        next_state = S_IF;
      end
      S_MEM_WR: begin
        mem_write  = 1'b1;
        i_or_d     = 1'b1;
        next_state = S_IF;
      end
      S_BR: begin
        alu_src_a     = 1'b1;
        pc_write_cond = 1'b1;
        pc_src        = 2'd1;
        next_state    = S_IF;
      end
      S_JMP: begin
        pc_write   = 1'b1;
        pc_src     = 2'd2;
        next_state = S_IF;
      end
      S_JAL: begin
        pc_write   = 1'b1;
        pc_src     = 2'd2;
        reg_write  = 1'b1;
        reg_dst    = 2'd2;
        mem_to_reg = 2'd2;
        next_state = S_IF;
      end
      S_JR: begin
        pc_write   = 1'b1;
        pc_src     = 2'd3;
        next_state = S_IF;
      end
`ifdef ILLEGAL_OP_TRAP_EN
      S_HALT:   next_state = S_HALT;
`endif
      default:  next_state = S_IF;
    endcase

    // Reset aborts whatever is in flight: no write side effects in the reset cycle.
    if (rst) begin
      next_state    = S_IF;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      mem_write     = 1'b0;
      reg_write     = 1'b0;
      ir_write      = 1'b0;
      mem_read      = 1'b0;
    end

    // ALU control registers its decode, so present the op one state early.
    case (next_state)
      S_EX_R:  alu_op = 2'b00;
      S_EX_I:  alu_op = (opcode == OP_SLTI) ? 2'b11 : 2'b01;
      S_BR:    alu_op = 2'b10;
      default: alu_op = 2'b01;
    endcase
  end

`ifdef ILLEGAL_OP_TRAP_EN
  assign halted = (state == S_HALT);
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_mc_main_cu.sv
// Self-checking bench for mc_main_cu: per-instruction phase plans from the opcode table,
// alu_op checked as the ALU function of the following cycle, retire count kept as plain arithmetic.
module tb_mc_main_cu;
  localparam int CW = 10;

  logic clk, rst, zero;
  logic [5:0] opcode, func;
  logic pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, reg_write, alu_src_a, halted;
  logic [1:0] reg_dst, mem_to_reg, alu_src_b, pc_src, alu_op;
  logic [CW-1:0] instr_count;

  mc_main_cu #(.COUNT_W(CW)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func(func), .zero(zero),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src),
    .alu_op(alu_op), .halted(halted), .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic [1:0] reg_dst, mem_to_reg;
    logic reg_write, alu_src_a;
    logic [1:0] alu_src_b, pc_src;
  } ctl_t;

  typedef struct packed {
    ctl_t ctl;
    logic [1:0] alu_use;
  } step_t;

  typedef enum {P_IF, P_ID, P_EXR, P_WBR, P_EXI_ADD, P_EXI_SLT, P_WBI, P_MA, P_MR,
                P_WBLW, P_MW, P_BR, P_J, P_JAL, P_JR} ph_t;

  int checks = 0;
  int errors = 0;
  int cnt = 0;
  ph_t plan[$];
  logic [5:0] legal_ops [8] = '{6'h00, 6'h08, 6'h0A, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h03};

  // What each phase drives, and which ALU function it relies on.
  function automatic step_t expect_of(ph_t p);
    step_t s;
    s = '0;
    s.alu_use = 2'b01;
    case (p)
      P_IF:      begin s.ctl.mem_read = 1; s.ctl.ir_write = 1; s.ctl.pc_write = 1; s.ctl.alu_src_b = 2'd1; end
      P_ID:      s.ctl.alu_src_b = 2'd3;
      P_EXR:     begin s.ctl.alu_src_a = 1; s.alu_use = 2'b00; end
      P_WBR:     begin s.ctl.reg_write = 1; s.ctl.reg_dst = 2'd1; end
      P_EXI_ADD: begin s.ctl.alu_src_a = 1; s.ctl.alu_src_b = 2'd2; end
      P_EXI_SLT: begin s.ctl.alu_src_a = 1; s.ctl.alu_src_b = 2'd2; s.alu_use = 2'b11; end
      P_WBI:     s.ctl.reg_write = 1;
      P_MA:      begin s.ctl.alu_src_a = 1; s.ctl.alu_src_b = 2'd2; end
      P_MR:      begin s.ctl.mem_read = 1; s.ctl.i_or_d = 1; end
      P_WBLW:    begin s.ctl.reg_write = 1; s.ctl.mem_to_reg = 2'd1; end
      P_MW:      begin s.ctl.mem_write = 1; s.ctl.i_or_d = 1; end
      P_BR:      begin s.ctl.alu_src_a = 1; s.ctl.pc_write_cond = 1; s.ctl.pc_src = 2'd1; s.alu_use = 2'b10; end
      P_J:       begin s.ctl.pc_write = 1; s.ctl.pc_src = 2'd2; end
      P_JAL:     begin s.ctl.pc_write = 1; s.ctl.pc_src = 2'd2; s.ctl.reg_write = 1;
                       s.ctl.reg_dst = 2'd2; s.ctl.mem_to_reg = 2'd2; end
      P_JR:      begin s.ctl.pc_write = 1; s.ctl.pc_src = 2'd3; end
      default:   s = '0;
    endcase
    return s;
  endfunction

  function automatic ctl_t observed();
    ctl_t c;
    c.pc_write = pc_write;   c.pc_write_cond = pc_write_cond; c.i_or_d = i_or_d;
    c.mem_read = mem_read;   c.mem_write = mem_write;         c.ir_write = ir_write;
    c.reg_dst = reg_dst;     c.mem_to_reg = mem_to_reg;       c.reg_write = reg_write;
    c.alu_src_a = alu_src_a; c.alu_src_b = alu_src_b;         c.pc_src = pc_src;
    return c;
  endfunction

  task automatic build_plan(input logic [5:0] op, input logic [5:0] f);
    plan.delete();
    plan.push_back(P_IF);
    plan.push_back(P_ID);
    case (op)
      6'h00: if (f == 6'h08) plan.push_back(P_JR);
             else begin plan.push_back(P_EXR); plan.push_back(P_WBR); end
      6'h08: begin plan.push_back(P_EXI_ADD); plan.push_back(P_WBI); end
      6'h0A: begin plan.push_back(P_EXI_SLT); plan.push_back(P_WBI); end
      6'h23: begin plan.push_back(P_MA); plan.push_back(P_MR); plan.push_back(P_WBLW); end
      6'h2B: begin plan.push_back(P_MA); plan.push_back(P_MW); end
      6'h04: plan.push_back(P_BR);
      6'h02: plan.push_back(P_J);
      6'h03: plan.push_back(P_JAL);
      default: ;
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_phase(input ph_t p, input logic [1:0] exp_alu);
    step_t e;
    e = expect_of(p);
    checks++;
    assert ({observed(), halted} === {e.ctl, 1'b0}) else begin
      errors++;
      $error("FAIL ctl %s: observed %h/%b expected %h/0", p.name(), observed(), halted, e.ctl);
    end
    checks++;
    assert (alu_op === exp_alu) else begin
      errors++;
      $error("FAIL alu_op %s: observed %b expected %b", p.name(), alu_op, exp_alu);
    end
  endtask

  task automatic check_count(input string tag);
    checks++;
    assert (instr_count === CW'(cnt)) else begin
      errors++;
      $error("FAIL count %s: observed %0d expected %0d", tag, instr_count, cnt);
    end
  endtask

  // Entered in the IF cycle; leaves in the IF cycle of the next instruction.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] f, input logic z);
    logic [1:0] nxt;
    opcode = op; func = f; zero = z;
    #1;
    build_plan(op, f);
    for (int i = 0; i < plan.size(); i++) begin
      nxt = (i + 1 < plan.size()) ? expect_of(plan[i+1]).alu_use : expect_of(P_IF).alu_use;
      check_phase(plan[i], nxt);
      step();
    end
    cnt = (cnt + 1) % (1 << CW);
    check_count("retire");
  endtask

  task automatic check_reset_cycle(input string tag);
    checks++;
    assert ({pc_write, pc_write_cond, mem_write, reg_write, ir_write, mem_read, alu_op} === 8'b00000001)
    else begin
      errors++;
      $error("FAIL %s: observed enables %b alu_op %b expected 000000 01", tag,
             {pc_write, pc_write_cond, mem_write, reg_write, ir_write, mem_read}, alu_op);
    end
  endtask

  initial begin
    rst = 1'b1; opcode = '0; func = '0; zero = 1'b0;
    step();
    step();
    check_reset_cycle("reset_hold");
    rst = 1'b0;
    #1;
    check_count("after_reset");

    // Directed: add, lw, sw, beq taken/not, slti, jal, jr, addi
    run_instr(6'h00, 6'h20, 1'b0);
    run_instr(6'h23, 6'h00, 1'b0);
    run_instr(6'h2B, 6'h00, 1'b0);
    run_instr(6'h04, 6'h00, 1'b1);
    run_instr(6'h04, 6'h00, 1'b0);
    run_instr(6'h0A, 6'h00, 1'b0);
    run_instr(6'h03, 6'h00, 1'b0);
    run_instr(6'h00, 6'h08, 1'b0);
    run_instr(6'h08, 6'h08, 1'b1);

    for (int n = 0; n < 150; n++) begin
      logic [5:0] op, f;
      op = legal_ops[$urandom_range(0, 7)];
      f = ($urandom_range(0, 3) == 0) ? 6'h08 : 6'($urandom_range(0, 63));
      run_instr(op, f, 1'($urandom_range(0, 1)));
    end

    // Reset in MEM_RD of a lw: no write, nothing retired.
    opcode = 6'h23; func = '0;
    #1;
    step(); step(); step();
    rst = 1'b1;
    #1;
    check_reset_cycle("reset_in_mem_rd");
    step();
    rst = 1'b0;
    #1;
    cnt = 0;
    check_count("after_abort");
    check_phase(P_IF, 2'b01);

    // Walk the counter to all-ones with jumps, then one more wraps it.
    while (cnt != (1 << CW) - 1) run_instr(6'h02, 6'h00, 1'b0);
    run_instr(6'h02, 6'h00, 1'b0);
    checks++;
    assert (instr_count === '0) else begin
      errors++;
      $error("FAIL wrap: observed %0d expected 0", instr_count);
    end

`ifdef ILLEGAL_OP_TRAP_EN
    opcode = 6'h3F; func = '0;
    #1;
    check_phase(P_IF, 2'b01);
    step();
    check_phase(P_ID, 2'b01);
    step();
    for (int k = 0; k < 10; k++) begin
      checks++;
      assert ({observed(), halted, alu_op, instr_count} === {16'h0000, 1'b1, 2'b01, CW'(cnt)}) else begin
        errors++;
        $error("FAIL halt[%0d]: observed ctl %h halted %b alu_op %b count %0d expected 0000 1 01 %0d",
               k, observed(), halted, alu_op, instr_count, cnt);
      end
      step();
    end
`else
    run_instr(6'h3F, 6'h00, 1'b0);
    run_instr(6'h00, 6'h00, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
